// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
// Shares one two-operand register-file read port among NUM_FU functional
// units. A token pointer rotates every cycle. The unit holding the token may
// read if both of its source registers are marked ready and the result path
// has room. Read data comes back through a 2-entry in-order feedback FIFO.
// Each grant is also reported to the scoreboard.
module rf_read_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int NUM_REG    = 8,
    parameter int REG_BIT    = 16,
    parameter int REG_ID_BIT = $clog2(NUM_REG),
    parameter int FU_ID_BIT  = $clog2(NUM_FU)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FU-1:0]              fu_req_vld,
    output logic [NUM_FU-1:0]              fu_req_rdy,
    input  logic [NUM_FU*REG_ID_BIT-1:0]   fu_reg0_id,
    input  logic [NUM_FU*REG_ID_BIT-1:0]   fu_reg1_id,
    input  logic [NUM_FU*REG_ID_BIT-1:0]   fu_dst_reg,
    input  logic [NUM_REG-1:0]             ready_reg_mask,
    output logic                           rf_rd_en,
    output logic [REG_ID_BIT-1:0]          rf_rd_addr0,
    output logic [REG_ID_BIT-1:0]          rf_rd_addr1,
    input  logic [REG_BIT-1:0]             rf_rd_data0,
    input  logic [REG_BIT-1:0]             rf_rd_data1,
    output logic [NUM_FU-1:0]              fu_fbk_vld,
    input  logic [NUM_FU-1:0]              fu_fbk_rdy,
    output logic [REG_BIT-1:0]             fu_fbk_val0,
    output logic [REG_BIT-1:0]             fu_fbk_val1,
    output logic                           grant_vld,
    output logic [FU_ID_BIT-1:0]           grant_fu,
    output logic [REG_ID_BIT-1:0]          grant_dst_reg,
    output logic                           idle
);

    // Last token position; the pointer wraps from here back to zero.
    localparam logic [FU_ID_BIT-1:0] PTR_LAST = FU_ID_BIT'(NUM_FU - 1);

    // Scoreboard lookup. An id beyond NUM_REG (possible when NUM_REG is not a
    // power of two) never names a real register, so it is treated as not ready.
    function automatic logic reg_is_ready(
        input logic [NUM_REG-1:0]    mask,
        input logic [REG_ID_BIT-1:0] id
    );
        logic ready;
        if (int'(id) < NUM_REG) begin
            ready = mask[id];
        end else begin
            ready = 1'b0;
        end
        return ready;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FU_ID_BIT-1:0] r_ptr;
    logic                 r_inflight_vld;
    logic [FU_ID_BIT-1:0] r_inflight_fu;

    // Two-entry FIFO. Write and read indices toggle, and the count
    // distinguishes full from empty.
    logic [REG_BIT-1:0]   r_fifo_val0 [2];
    logic [REG_BIT-1:0]   r_fifo_val1 [2];
    logic [FU_ID_BIT-1:0] r_fifo_fu   [2];
    logic                 r_wr_idx;
    logic                 r_rd_idx;
    logic [1:0]           r_fifo_cnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [REG_ID_BIT-1:0] w_reg0_id;
    logic [REG_ID_BIT-1:0] w_reg1_id;
    logic [REG_ID_BIT-1:0] w_dst_id;
    logic                  w_head_vld;
    logic [FU_ID_BIT-1:0]  w_head_fu;
    logic                  w_drain_now;
    logic [2:0]            w_occupancy;
    logic                  w_can_accept;
    logic                  w_slot_rdy;
    logic                  w_grant;
    logic                  w_push;
    logic [FU_ID_BIT-1:0]  w_ptr_nxt;
    logic [1:0]            w_fifo_cnt_nxt;

    // Select the token holder's register ids from the packed request buses.
    always_comb begin
        w_reg0_id = fu_reg0_id[int'(r_ptr) * REG_ID_BIT +: REG_ID_BIT];
        w_reg1_id = fu_reg1_id[int'(r_ptr) * REG_ID_BIT +: REG_ID_BIT];
        w_dst_id  = fu_dst_reg[int'(r_ptr) * REG_ID_BIT +: REG_ID_BIT];
    end

    // Result-path capacity. A result the head hands over this cycle frees
    // its slot in time for a new grant, so throughput stays at one per cycle.
    always_comb begin
        w_head_vld = (r_fifo_cnt != 2'd0);
        w_head_fu  = r_fifo_fu[r_rd_idx];
        if (w_head_vld) begin
            w_drain_now = fu_fbk_rdy[w_head_fu];
        end else begin
            w_drain_now = 1'b0;
        end
        w_occupancy  = {1'b0, r_fifo_cnt} + {2'b00, r_inflight_vld} - {2'b00, w_drain_now};
        w_can_accept = (w_occupancy < 3'd2);
    end

    // Slot readiness and grant. Ready never looks at fu_req_vld, so a unit
    // may gate its valid with its ready without forming a loop.
    always_comb begin
        if (rst) begin
            w_slot_rdy = 1'b0;
        end else begin
            w_slot_rdy = w_can_accept
                       && reg_is_ready(ready_reg_mask, w_reg0_id)
                       && reg_is_ready(ready_reg_mask, w_reg1_id);
        end
        w_grant = w_slot_rdy && fu_req_vld[r_ptr];
        w_push  = r_inflight_vld;
    end

    // One-hot ready for the token holder only.
    always_comb begin
        fu_req_rdy = {NUM_FU{1'b0}};
        if (w_slot_rdy) begin
            fu_req_rdy[r_ptr] = 1'b1;
        end else begin
            fu_req_rdy = {NUM_FU{1'b0}};
        end
    end

    // Read port and scoreboard report follow the grant in the same cycle.
    // With no grant the addresses simply show the token holder's ids.
    always_comb begin
        rf_rd_en      = w_grant;
        rf_rd_addr0   = w_reg0_id;
        rf_rd_addr1   = w_reg1_id;
        grant_vld     = w_grant;
        grant_fu      = r_ptr;
        grant_dst_reg = w_dst_id;
    end

    // Feedback comes from the FIFO head, so it is a decode of registered state.
    always_comb begin
        fu_fbk_vld = {NUM_FU{1'b0}};
        if (w_head_vld) begin
            fu_fbk_vld[w_head_fu] = 1'b1;
        end else begin
            fu_fbk_vld = {NUM_FU{1'b0}};
        end
        fu_fbk_val0 = r_fifo_val0[r_rd_idx];
        fu_fbk_val1 = r_fifo_val1[r_rd_idx];
        idle        = !r_inflight_vld && (r_fifo_cnt == 2'd0);
    end

    // Next token position, wrapping at NUM_FU-1 (NUM_FU need not be 2^n).
    always_comb begin
        if (r_ptr == PTR_LAST) begin
            w_ptr_nxt = {FU_ID_BIT{1'b0}};
        end else begin
            w_ptr_nxt = r_ptr + {{(FU_ID_BIT-1){1'b0}}, 1'b1};
        end
    end

    // FIFO count update. A push and a pop in the same cycle cancel.
    always_comb begin
        case ({w_push, w_drain_now})
            2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + 2'd1;
            2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - 2'd1;
            default: w_fifo_cnt_nxt = r_fifo_cnt;
        endcase
    end

    // Token pointer advances every cycle, whether or not a grant happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= {FU_ID_BIT{1'b0}};
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Track the read in flight. Its data arrives from the RF next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight_vld <= 1'b0;
            r_inflight_fu  <= {FU_ID_BIT{1'b0}};
        end else begin
            r_inflight_vld <= w_grant;
            r_inflight_fu  <= r_ptr;
        end
    end

    // FIFO control: indices and count. Reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx   <= 1'b0;
            r_rd_idx   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_idx <= ~r_wr_idx;
            end
            if (w_drain_now) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_fifo_cnt <= w_fifo_cnt_nxt;
        end
    end

    // FIFO storage. No reset is needed because the count qualifies the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_val0[r_wr_idx] <= rf_rd_data0;
            r_fifo_val1[r_wr_idx] <= rf_rd_data1;
            r_fifo_fu[r_wr_idx]   <= r_inflight_fu;
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench for rf_read_arbiter (NUM_FU=4, NUM_REG=8, REG_BIT=16).
// Stimulus pushes hand-computed grants and feedback into queues. A monitor
// thread pops and compares them when the DUT presents them.
module tb_rf_read_arbiter;

    localparam int NF  = 4;
    localparam int NR  = 8;
    localparam int RB  = 16;
    localparam int RIB = 3;
    localparam int FIB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NF-1:0]     fu_req_vld;
    logic [NF-1:0]     fu_req_rdy;
    logic [NF*RIB-1:0] fu_reg0_id;
    logic [NF*RIB-1:0] fu_reg1_id;
    logic [NF*RIB-1:0] fu_dst_reg;
    logic [NR-1:0]     ready_reg_mask;
    logic              rf_rd_en;
    logic [RIB-1:0]    rf_rd_addr0;
    logic [RIB-1:0]    rf_rd_addr1;
    logic [RB-1:0]     rf_rd_data0;
    logic [RB-1:0]     rf_rd_data1;
    logic [NF-1:0]     fu_fbk_vld;
    logic [NF-1:0]     fu_fbk_rdy;
    logic [RB-1:0]     fu_fbk_val0;
    logic [RB-1:0]     fu_fbk_val1;
    logic              grant_vld;
    logic [FIB-1:0]    grant_fu;
    logic [RIB-1:0]    grant_dst_reg;
    logic              idle;

    rf_read_arbiter #(.NUM_FU(NF), .NUM_REG(NR), .REG_BIT(RB)) dut (
        .clk(clk), .rst(rst),
        .fu_req_vld(fu_req_vld), .fu_req_rdy(fu_req_rdy),
        .fu_reg0_id(fu_reg0_id), .fu_reg1_id(fu_reg1_id), .fu_dst_reg(fu_dst_reg),
        .ready_reg_mask(ready_reg_mask),
        .rf_rd_en(rf_rd_en), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
        .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
        .fu_fbk_vld(fu_fbk_vld), .fu_fbk_rdy(fu_fbk_rdy),
        .fu_fbk_val0(fu_fbk_val0), .fu_fbk_val1(fu_fbk_val1),
        .grant_vld(grant_vld), .grant_fu(grant_fu), .grant_dst_reg(grant_dst_reg),
        .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct { int fu; logic [2:0] a0; logic [2:0] a1; logic [2:0] dst; } grant_t;
    typedef struct { int fu; logic [15:0] v0; logic [15:0] v1; } fbk_t;

    grant_t gq[$];
    fbk_t   fq[$];
    int     n_err = 0;
    int     n_chk = 0;
    int     tok   = 0;

    // Register-file contents as seen by the bench's RF responder.
    function automatic logic [15:0] rf_val(input logic [2:0] r);
        case (r)
            3'd0:    return 16'h00A0;
            3'd1:    return 16'd5;
            3'd2:    return 16'd7;
            3'd3:    return 16'h0333;
            3'd4:    return 16'h0444;
            3'd5:    return 16'h0555;
            3'd6:    return 16'h0666;
            default: return 16'h0777;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic set_unit(input int u, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        fu_reg0_id[u*RIB +: RIB] = a;
        fu_reg1_id[u*RIB +: RIB] = b;
        fu_dst_reg[u*RIB +: RIB] = d;
    endtask

    task automatic exp_grant(input int u, input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] d, input bit with_fbk);
        grant_t g;
        fbk_t   f;
        g.fu = u; g.a0 = a; g.a1 = b; g.dst = d;
        gq.push_back(g);
        if (with_fbk) begin
            f.fu = u; f.v0 = rf_val(a); f.v1 = rf_val(b);
            fq.push_back(f);
        end
    endtask

    // Advance one cycle and track the token position the DUT should hold.
    task automatic step();
        @(posedge clk);
        tok = rst ? 0 : ((tok + 1) % NF);
        #1;
    endtask

    task automatic wait_tok(input int t);
        while (tok != t) step();
    endtask

    // RF responder: data for a read issued in cycle T is driven in T+1.
    initial begin
        logic       en;
        logic [2:0] a0;
        logic [2:0] a1;
        rf_rd_data0 = 16'h0;
        rf_rd_data1 = 16'h0;
        forever begin
            @(negedge clk);
            en = rf_rd_en; a0 = rf_rd_addr0; a1 = rf_rd_addr1;
            @(posedge clk);
            #1;
            rf_rd_data0 = en ? rf_val(a0) : 16'hDEAD;
            rf_rd_data1 = en ? rf_val(a1) : 16'hBEEF;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pat2;
        logic [11:0] pat4;
        grant_t g;
        fbk_t   f;

        rst = 1'b1;
        fu_req_vld = 4'hF;
        fu_reg0_id = '0; fu_reg1_id = '0; fu_dst_reg = '0;
        ready_reg_mask = 8'hFF;
        fu_fbk_rdy = 4'hF;

        // Monitor: compare grants and accepted feedback against the queues.
        fork
            forever begin
                @(negedge clk);
                if (!rst && grant_vld) begin
                    if (gq.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_grant: got fu %0d expected none", grant_fu);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_fu",   32'(grant_fu),      32'(g.fu));
                        chk("rd_addr0",   32'(rf_rd_addr0),   32'(g.a0));
                        chk("rd_addr1",   32'(rf_rd_addr1),   32'(g.a1));
                        chk("grant_dst",  32'(grant_dst_reg), 32'(g.dst));
                        chk("rf_rd_en",   32'(rf_rd_en),      32'd1);
                    end
                end
                if (!rst && ((fu_fbk_vld & fu_fbk_rdy) != 4'h0)) begin
                    if (fq.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_fbk: got vld %b expected none", fu_fbk_vld);
                    end else begin
                        f = fq.pop_front();
                        chk("fbk_vld",  32'(fu_fbk_vld),  32'(4'b0001 << f.fu));
                        chk("fbk_val0", 32'(fu_fbk_val0), 32'(f.v0));
                        chk("fbk_val1", 32'(fu_fbk_val1), 32'(f.v1));
                    end
                end
            end
        join_none

        // Reset state (requests and ready operands present but must be masked).
        step();
        @(negedge clk);
        chk("rst_req_rdy", 32'(fu_req_rdy), 32'd0);
        chk("rst_fbk_vld", 32'(fu_fbk_vld), 32'd0);
        chk("rst_rd_en",   32'(rf_rd_en),   32'd0);
        chk("rst_grant",   32'(grant_vld),  32'd0);
        chk("rst_idle",    32'(idle),       32'd1);
        step();

        // T1: unit 0 reads r1/r2 in cycle 0, feedback 5/7 two cycles later.
        rst = 1'b0;
        fu_req_vld = 4'b0001;
        set_unit(0, 3'd1, 3'd2, 3'd5);
        exp_grant(0, 3'd1, 3'd2, 3'd5, 1'b1);
        @(negedge clk);
        chk("t1_grant", 32'(grant_vld), 32'd1);
        step();
        fu_req_vld = 4'b0000;
        @(negedge clk);
        chk("t1_fbk_t1", 32'(fu_fbk_vld), 32'd0);
        step();
        @(negedge clk);
        chk("t1_fbk_t2", 32'(fu_fbk_vld), 32'b0001);
        chk("t1_val0",   32'(fu_fbk_val0), 32'd5);
        chk("t1_val1",   32'(fu_fbk_val1), 32'd7);
        step();

        // T2: units 1 and 3 request continuously; grants alternate 1,3,1,3.
        wait_tok(0);
        set_unit(1, 3'd3, 3'd4, 3'd1);
        set_unit(3, 3'd5, 3'd6, 3'd2);
        fu_req_vld = 4'b1010;
        exp_grant(1, 3'd3, 3'd4, 3'd1, 1'b1);
        exp_grant(3, 3'd5, 3'd6, 3'd2, 1'b1);
        exp_grant(1, 3'd3, 3'd4, 3'd1, 1'b1);
        exp_grant(3, 3'd5, 3'd6, 3'd2, 1'b1);
        pat2 = 8'b1010_1010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t2_grant", 32'(grant_vld), 32'(pat2[c]));
            step();
        end
        fu_req_vld = 4'b0000;
        repeat (4) step();

        // T3: unit 2 blocked by r4 not ready, granted on its next slot.
        set_unit(2, 3'd4, 3'd0, 3'd7);
        ready_reg_mask = 8'hEF;
        fu_req_vld = 4'b0100;
        wait_tok(2);
        @(negedge clk);
        chk("t3_rdy_blocked", 32'(fu_req_rdy), 32'd0);
        chk("t3_no_grant",    32'(grant_vld),  32'd0);
        step();
        wait_tok(1);
        ready_reg_mask = 8'hFF;
        exp_grant(2, 3'd4, 3'd0, 3'd7, 1'b1);
        step();
        @(negedge clk);
        chk("t3_rdy_open", 32'(fu_req_rdy), 32'b0100);
        chk("t3_grant",    32'(grant_vld),  32'd1);
        step();
        fu_req_vld = 4'b0000;
        repeat (4) step();

        // T4: all request, no feedback accepted: 2 grants, then stall; release drains in order.
        wait_tok(0);
        fu_fbk_rdy = 4'h0;
        fu_req_vld = 4'hF;
        exp_grant(0, 3'd1, 3'd2, 3'd5, 1'b1);
        exp_grant(1, 3'd3, 3'd4, 3'd1, 1'b1);
        exp_grant(0, 3'd1, 3'd2, 3'd5, 1'b1);
        exp_grant(1, 3'd3, 3'd4, 3'd1, 1'b1);
        exp_grant(2, 3'd4, 3'd0, 3'd7, 1'b1);
        exp_grant(3, 3'd5, 3'd6, 3'd2, 1'b1);
        pat4 = 12'b1111_0000_0011;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) fu_fbk_rdy = 4'hF;
            @(negedge clk);
            chk("t4_grant", 32'(grant_vld), 32'(pat4[c]));
            if (c >= 2 && c < 8) begin
                chk("t4_rdy_stall", 32'(fu_req_rdy), 32'd0);
                chk("t4_head_held", 32'(fu_fbk_vld), 32'b0001);
                chk("t4_not_idle",  32'(idle),       32'd0);
            end
            step();
        end
        fu_req_vld = 4'b0000;
        repeat (6) step();

        // T5: unit 1 reads r3,r2 with destination r3.
        set_unit(1, 3'd3, 3'd2, 3'd3);
        fu_req_vld = 4'b0010;
        wait_tok(1);
        exp_grant(1, 3'd3, 3'd2, 3'd3, 1'b1);
        @(negedge clk);
        chk("t5_grant_fu",  32'(grant_fu),      32'd1);
        chk("t5_grant_dst", 32'(grant_dst_reg), 32'd3);
        step();
        fu_req_vld = 4'b0000;
        repeat (4) step();

        // T6: reset one cycle after a grant drops the in-flight result.
        fu_req_vld = 4'b0001;
        wait_tok(0);
        exp_grant(0, 3'd1, 3'd2, 3'd5, 1'b0);
        @(negedge clk);
        chk("t6_grant", 32'(grant_vld), 32'd1);
        step();
        fu_req_vld = 4'b0000;
        @(negedge clk);
        chk("t6_busy", 32'(idle), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_fbk",  32'(fu_fbk_vld), 32'd0);
        chk("t6_rst_idle", 32'(idle),       32'd1);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_no_fbk",  32'(fu_fbk_vld), 32'd0);
            chk("t6_idle",    32'(idle),       32'd1);
            step();
        end

        chk("grant_q_empty", 32'(gq.size()), 32'd0);
        chk("fbk_q_empty",   32'(fq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
